// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and constant helpers for the pipeline stage library.
package pipe_pkg;
    localparam int PIPE_DEFAULT_WIDTH = 32;

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction
endpackage

// File: rtl/pipe_skid_fifo.sv
// pipe_skid_fifo: circular skid buffer with push/pop/clear; any DEPTH >= 1,
// pointers wrap at DEPTH-1 so non-power-of-two depths work.
module pipe_skid_fifo import pipe_pkg::*; #(
    parameter int WIDTH = PIPE_DEFAULT_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: only entries counted in 'count' are ever read.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wr_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register backed by a DEPTH-entry skid FIFO.
// Optional stall counter output enabled by PIPE_SKID_STALL_STATS_EN.
module pipe_skid_stage import pipe_pkg::*; #(
    parameter int WIDTH = PIPE_DEFAULT_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = clog2(DEPTH + 2)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] occupancy_o
`ifdef PIPE_SKID_STALL_STATS_EN
    ,
    output logic [31:0]      stall_cnt_o
`endif
);
    logic             in_xfer, load_en, push, pop, full, empty;
    logic [WIDTH-1:0] head;
    logic [CNT_W-1:0] skid_count;

    assign ready_o = ~full;
    assign in_xfer = valid_i & ready_o;
    assign load_en = ~valid_o | ready_i;
    // Incoming data bypasses the skid only when the output slot frees and nothing is queued.
    assign push    = in_xfer & ~flush_i & ~(load_en & empty);
    assign pop     = load_en & ~empty & ~flush_i;
    assign occupancy_o = skid_count + CNT_W'(valid_o);

    pipe_skid_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .clear   (flush_i),
        .push    (push),
        .pop     (pop),
        .wr_data (data_i),
        .count   (skid_count),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (load_en) begin
            if (!empty) begin
                valid_o <= 1'b1;
                data_o  <= head;
            end else if (in_xfer) begin
                valid_o <= 1'b1;
                data_o  <= data_i;
            end else begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef PIPE_SKID_STALL_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) stall_cnt_o <= '0;
        else if (valid_o && !ready_i && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: drives a DEPTH=2 and a DEPTH=3 stage with shared stimulus and
// checks both against queue models; covers PIPE_SKID_STALL_STATS_EN when defined.
module tb_pipe_skid_stage;
    logic        clk = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_i;
    logic [31:0] data_i;
    logic        ready_a, valid_a, ready_b, valid_b;
    logic [31:0] data_a, data_b;
    logic [1:0]  occ_a;
    logic [2:0]  occ_b;
`ifdef PIPE_SKID_STALL_STATS_EN
    logic [31:0] stall_a, stall_b;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] qa[$], qb[$];
    logic [31:0] la = '0, lb = '0;
    logic [31:0] sa = '0, sb = '0;
    logic [31:0] obs[$];

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(32), .DEPTH(2)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_a),
        .data_i(data_i), .valid_o(valid_a), .ready_i(ready_i), .data_o(data_a), .occupancy_o(occ_a)
`ifdef PIPE_SKID_STALL_STATS_EN
        , .stall_cnt_o(stall_a)
`endif
    );

    pipe_skid_stage #(.WIDTH(32), .DEPTH(3)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_b),
        .data_i(data_i), .valid_o(valid_b), .ready_i(ready_i), .data_o(data_b), .occupancy_o(occ_b)
`ifdef PIPE_SKID_STALL_STATS_EN
        , .stall_cnt_o(stall_b)
`endif
    );

    // Everything in flight counts; the oldest item sits in the output register.
    function automatic logic can_accept(input int size, input int depth);
        return ((size > 0) ? size - 1 : 0) < depth;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_all();
        chk("a_valid", {31'b0, valid_a}, {31'b0, qa.size() > 0});
        chk("a_data", data_a, la);
        chk("a_occ", {30'b0, occ_a}, qa.size());
        chk("a_ready", {31'b0, ready_a}, {31'b0, can_accept(qa.size(), 2)});
        chk("b_valid", {31'b0, valid_b}, {31'b0, qb.size() > 0});
        chk("b_data", data_b, lb);
        chk("b_occ", {29'b0, occ_b}, qb.size());
        chk("b_ready", {31'b0, ready_b}, {31'b0, can_accept(qb.size(), 3)});
`ifdef PIPE_SKID_STALL_STATS_EN
        chk("a_stall", stall_a, sa);
        chk("b_stall", stall_b, sb);
`endif
    endtask

    task automatic model_clear();
        qa.delete();
        qb.delete();
        la = '0;
        lb = '0;
    endtask

    task automatic step();
        logic ia, ib, oa, ob;
        ia = valid_i && can_accept(qa.size(), 2);
        ib = valid_i && can_accept(qb.size(), 3);
        oa = (qa.size() > 0) && ready_i;
        ob = (qb.size() > 0) && ready_i;
        if (qa.size() > 0 && !ready_i && sa != 32'hFFFF_FFFF) sa++;
        if (qb.size() > 0 && !ready_i && sb != 32'hFFFF_FFFF) sb++;
        @(posedge clk);
        #1;
        if (flush_i) begin
            model_clear();
        end else begin
            if (oa) void'(qa.pop_front());
            if (ia) qa.push_back(data_i);
            if (qa.size() > 0) la = qa[0];
            if (ob) void'(qb.pop_front());
            if (ib) qb.push_back(data_i);
            if (qb.size() > 0) lb = qb[0];
        end
        check_all();
    endtask

    initial begin
        int w, cyc;
        logic [3:0] pat;
        rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        #12;
        check_all();
        rst_i = 1'b1;

        // single transfer into an empty stage
        valid_i = 1'b1; data_i = 32'hA5A5_0001; ready_i = 1'b1;
        step();
        chk("t1_data", data_a, 32'hA5A5_0001);
        chk("t1_occ", {30'b0, occ_a}, 32'd1);
        chk("t1_ready", {31'b0, ready_a}, 32'd1);
        valid_i = 1'b0;
        step();

        // back-pressure fills the DEPTH=2 skid
        ready_i = 1'b0; valid_i = 1'b1;
        data_i = 32'h11; step();
        data_i = 32'h22; step();
        data_i = 32'h33; step();
        chk("bp_occ", {30'b0, occ_a}, 32'd3);
        chk("bp_ready", {31'b0, ready_a}, 32'd0);
        chk("bp_hold", data_a, 32'h11);
        data_i = 32'h44; step();
        chk("bp_reject_occ", {30'b0, occ_a}, 32'd3);
        valid_i = 1'b0; ready_i = 1'b1;
        step();
        chk("drain1", data_a, 32'h22);
        chk("drain_ready", {31'b0, ready_a}, 32'd1);
        step();
        chk("drain2", data_a, 32'h33);
        repeat (3) step();

        // flush with two skid entries and an incoming word
        ready_i = 1'b0; valid_i = 1'b1;
        data_i = 32'h55; step();
        data_i = 32'h66; step();
        data_i = 32'h88; step();
        data_i = 32'h77; flush_i = 1'b1;
        step();
        chk("fl_valid", {31'b0, valid_a}, 32'd0);
        chk("fl_data", data_a, 32'd0);
        chk("fl_occ", {30'b0, occ_a}, 32'd0);
        chk("fl_ready", {31'b0, ready_a}, 32'd1);
        flush_i = 1'b0; valid_i = 1'b0;
        step();

        // DEPTH=3 wrap-around stream 1..10 with ready pattern 1,0,0,1
        pat = 4'b1001; w = 1; cyc = 0;
        while (cyc < 200 && w <= 10) begin
            valid_i = 1'b1; data_i = w; ready_i = pat[cyc % 4];
            if (valid_b && ready_i) obs.push_back(data_b);
            if (can_accept(qb.size(), 3)) w++;
            step();
            cyc++;
        end
        valid_i = 1'b0; ready_i = 1'b1;
        repeat (8) begin
            if (valid_b && ready_i) obs.push_back(data_b);
            step();
        end
        chk("wrap_count", obs.size(), 32'd10);
        for (int k = 0; k < obs.size() && k < 10; k++) chk("wrap_order", obs[k], k + 1);

        // randomized traffic with occasional flush
        repeat (400) begin
            valid_i = $urandom_range(1);
            ready_i = $urandom_range(3) != 0;
            flush_i = $urandom_range(15) == 0;
            data_i  = $urandom;
            step();
        end
        flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
        repeat (5) begin
            data_i = $urandom;
            step();
        end

        // asynchronous reset between edges while full
        #3 rst_i = 1'b0;
        #1;
        chk("ar_valid_a", {31'b0, valid_a}, 32'd0);
        chk("ar_occ_a", {30'b0, occ_a}, 32'd0);
        chk("ar_valid_b", {31'b0, valid_b}, 32'd0);
        chk("ar_occ_b", {29'b0, occ_b}, 32'd0);
        model_clear();
        sa = '0; sb = '0;
        check_all();
        #1 rst_i = 1'b1;

        // stall statistics
        valid_i = 1'b1; data_i = 32'h99; ready_i = 1'b0;
        step();
        valid_i = 1'b0;
        repeat (5) step();
`ifdef PIPE_SKID_STALL_STATS_EN
        chk("stall5", stall_a, 32'd5);
`endif
        flush_i = 1'b1; ready_i = 1'b1;
        step();
        flush_i = 1'b0;
`ifdef PIPE_SKID_STALL_STATS_EN
        chk("stall_flush", stall_a, 32'd5);
`endif
        #3 rst_i = 1'b0;
        #1;
        sa = '0; sb = '0;
        model_clear();
        check_all();
        #1 rst_i = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
